// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage in front of the 32-bit ALU. Decodes the operation class and
//   funct3/funct7b5 into the ALU's 3-bit operation code and picks operand B
//   (register or immediate). Decoded operations go into a 2-entry FIFO. The
//   head entry drives the ALU operands straight from storage.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   flush                 synchronous buffer clear (issue counter kept)
//   in_valid / in_ready   upstream handshake; in_ready depends only on state
//   in_class, in_funct3,  decoded instruction fields
//   in_funct7b5
//   in_rs1, in_rs2,       register operands and sign-extended immediate
//   in_imm
//   out_valid / out_ready downstream handshake on the head entry
//   out_a, out_b,         head entry: ALU operands, operation code and
//   out_aluop, out_illegal  unsupported-operation flag
//   issued_count          output handshakes, modulo 2^CNT_W
module alu_issue_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [2:0]       out_aluop,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_count
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        CLS_R    = 2'b00,
        CLS_I    = 2'b01,
        CLS_ADDR = 2'b10,
        CLS_RSVD = 2'b11
    } class_e;

    // Decode (input side)
    aluop_e          dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] dec_b;

    always_comb begin
        dec_op  = OP_AND;
        dec_ill = 1'b0;
        dec_b   = (class_e'(in_class) == CLS_R) ? in_rs2 : in_imm;
        case (class_e'(in_class))
            CLS_ADDR: dec_op = OP_ADD;
            CLS_RSVD: dec_ill = 1'b1;
            default: begin
                case (in_funct3)
                    // funct7b5 selects SUB only for register-register ops
                    3'b000:  dec_op = (class_e'(in_class) == CLS_R && in_funct7b5) ? OP_SUB : OP_ADD;
                    3'b010:  dec_op = OP_SLT;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // 2-entry FIFO
    logic [XLEN-1:0]  mem_a   [2];
    logic [XLEN-1:0]  mem_b   [2];
    aluop_e           mem_op  [2];
    logic             mem_ill [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign in_ready     = (count != 2'd2);
    assign out_valid    = (count != 2'd0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;

    assign out_a        = mem_a[head];
    assign out_b        = mem_b[head];
    assign out_aluop    = mem_op[head];
    assign out_illegal  = mem_ill[head];
    assign issued_count = cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            cnt   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_a[i]   <= '0;
                mem_b[i]   <= '0;
                mem_op[i]  <= OP_AND;
                mem_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            // Drops contents and any same-cycle push/pop; counter untouched.
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem_a[tail]   <= in_rs1;
                mem_b[tail]   <= dec_b;
                mem_op[tail]  <= dec_op;
                mem_ill[tail] <= dec_ill;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                cnt  <= cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    typedef struct {
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic        eill;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_aluop;
    logic        out_illegal;
    logic [3:0]  issued_count;

    alu_issue_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_aluop(out_aluop),
        .out_illegal(out_illegal), .issued_count(issued_count)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   passed = 0;
    exp_t sbq[$];
    exp_t cur_exp;
    logic [3:0] exp_cnt = '0;
    logic mon_en = 1'b0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: samples 1ns before each rising edge.
    always begin
        @(negedge clock);
        #4;
        if (!reset_n) begin
            sbq.delete();
            exp_cnt = '0;
        end else if (mon_en) begin
            logic mpop, mpush;
            chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sbq.size() != 2));
            chk("issued_count", 32'(issued_count), 32'(exp_cnt));
            if (out_valid && sbq.size() != 0) begin
                chk("head_a", out_a, sbq[0].a);
                chk("head_b", out_b, sbq[0].b);
                chk("head_aluop", 32'(out_aluop), 32'(sbq[0].op));
                chk("head_illegal", 32'(out_illegal), 32'(sbq[0].ill));
            end
            mpop  = (sbq.size() != 0) && out_ready;
            mpush = in_valid && (sbq.size() < 2);
            if (flush) sbq.delete();
            else begin
                if (mpop) begin
                    void'(sbq.pop_front());
                    exp_cnt = exp_cnt + 4'd1;
                end
                if (mpush) sbq.push_back(cur_exp);
            end
        end
    end

    task automatic drive(input vec_t v);
        in_valid    = 1'b1;
        in_class    = v.cls;
        in_funct3   = v.f3;
        in_funct7b5 = v.f7;
        in_rs1      = v.rs1;
        in_rs2      = v.rs2;
        in_imm      = v.imm;
        cur_exp.a   = v.rs1;
        cur_exp.b   = v.eb;
        cur_exp.op  = v.eop;
        cur_exp.ill = v.eill;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input vec_t v);
        logic acc;
        acc = 1'b0;
        drive(v);
        for (int t = 0; t < 20 && !acc; t++) begin
            #4;
            acc = in_ready;
            @(negedge clock);
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && out_valid; t++) @(negedge clock);
        chk("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        time t0;
        vec_t z;
        logic [3:0] cnt_before;

        //          cls    f3      f7    rs1           rs2           imm           exp_b         op      ill
        tbl[0]  = '{2'b00, 3'b000, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000055, 32'h00000003, 3'b110, 1'b0};
        tbl[1]  = '{2'b00, 3'b000, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h22222222, 3'b010, 1'b0};
        tbl[2]  = '{2'b01, 3'b000, 1'b1, 32'h00000100, 32'h00000200, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b0};
        tbl[3]  = '{2'b10, 3'b010, 1'b0, 32'h80000000, 32'h00000001, 32'h00000010, 32'h00000010, 3'b010, 1'b0};
        tbl[4]  = '{2'b01, 3'b110, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0000F00F, 32'h0000F00F, 3'b001, 1'b0};
        tbl[5]  = '{2'b00, 3'b010, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 3'b111, 1'b0};
        tbl[6]  = '{2'b00, 3'b111, 1'b1, 32'h0F0F0F0F, 32'hFF00FF00, 32'h00000007, 32'hFF00FF00, 3'b000, 1'b0};
        tbl[7]  = '{2'b00, 3'b100, 1'b0, 32'h00000044, 32'h00000088, 32'h000000CC, 32'h00000088, 3'b000, 1'b1};
        tbl[8]  = '{2'b11, 3'b000, 1'b0, 32'h00000099, 32'h000000AA, 32'h000000BB, 32'h000000BB, 3'b000, 1'b1};
        tbl[9]  = '{2'b01, 3'b001, 1'b0, 32'h00001234, 32'h00005678, 32'h00009ABC, 32'h00009ABC, 3'b000, 1'b1};
        tbl[10] = '{2'b10, 3'b101, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFF8, 3'b010, 1'b0};
        tbl[11] = '{2'b00, 3'b110, 1'b1, 32'h00F000F0, 32'h0F000F00, 32'h0000000F, 32'h0F000F00, 3'b001, 1'b0};

        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(issued_count), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_aluop", 32'(out_aluop), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        @(negedge clock);

        // R-type SUB with 1-cycle latency
        out_ready = 1'b1;
        send(tbl[0]);
        #1;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_a", out_a, 32'h0000000A);
        chk("sub_b", out_b, 32'h00000003);
        chk("sub_aluop", 32'(out_aluop), 32'b110);
        @(negedge clock);
        #1;
        chk("sub_count", 32'(issued_count), 32'd1);
        @(negedge clock);

        // Table sweep back-to-back: one op per cycle
        t0 = $time;
        for (int i = 0; i < 12; i++) send(tbl[i]);
        chk("throughput", 32'($time - t0), 32'd120);
        drain();

        // Backpressure: X, Y accepted, Z held until first pop
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[5]);
        #1;
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        z = tbl[7];
        drive(z);
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
        send(z);
        drain();

        // Flush with a same-cycle push and pop
        out_ready = 1'b0;
        send(tbl[2]);
        cnt_before = issued_count;
        drive(tbl[3]);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_count", 32'(issued_count), 32'(cnt_before));
        @(negedge clock);

        // Reset mid-operation with input presented
        out_ready = 1'b0;
        send(tbl[4]);
        send(tbl[6]);
        drive(tbl[9]);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_count", 32'(issued_count), 32'd0);
        chk("mid_rst_out_a", out_a, 32'd0);
        @(negedge clock);

        // Counter wrap with CNT_W=4: 17 pops
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(tbl[i % 12]);
        drain();
        #1;
        chk("wrap_count", 32'(issued_count), 32'd1);
        @(negedge clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
